// File: rtl/brl_if.sv
// brl_if: request/grant, operand, shifter and result signals of brl_sched.
//   Port A/B: req_x, mode_x[1:0], cnt_x[31:0], data_x[31:0] in; gnt_x, done_x out.
//   Shifter side: brlmux_0/1, srcdp, brld out; brlq, brl_carry in.
//   Result side: res_q, res_c, busy out.
interface brl_if;
  logic        req_a;
  logic [1:0]  mode_a;
  logic [31:0] cnt_a;
  logic [31:0] data_a;
  logic        gnt_a;
  logic        done_a;
  logic        req_b;
  logic [1:0]  mode_b;
  logic [31:0] cnt_b;
  logic [31:0] data_b;
  logic        gnt_b;
  logic        done_b;
  logic        brlmux_0;
  logic        brlmux_1;
  logic [31:0] srcdp;
  logic [31:0] brld;
  logic [31:0] brlq;
  logic        brl_carry;
  logic [31:0] res_q;
  logic        res_c;
  logic        busy;
  modport master (
    output req_a, mode_a, cnt_a, data_a, req_b, mode_b, cnt_b, data_b, brlq, brl_carry,
    input  gnt_a, done_a, gnt_b, done_b, brlmux_0, brlmux_1, srcdp, brld, res_q, res_c, busy
  );
  modport slave (
    input  req_a, mode_a, cnt_a, data_a, req_b, mode_b, cnt_b, data_b, brlq, brl_carry,
    output gnt_a, done_a, gnt_b, done_b, brlmux_0, brlmux_1, srcdp, brld, res_q, res_c, busy
  );
endinterface

// File: rtl/brl_sched.sv
// brl_sched: shares one barrel shifter between port A (ALU) and port B (background).
//   clk, reset (async, active-high) plain ports; everything else on bus (brl_if.slave).
//   Stage 1: operand registers to the shifter + valid/id. Stage 2: result + tagged done.
//   Port B wins a contention once it has lost STARVE_MAX in a row.
module brl_sched #(
  parameter int STARVE_MAX = 3
) (
  input logic clk,
  input logic reset,
  brl_if.slave bus
);
  localparam logic [1:0] SMAX = 2'(STARVE_MAX);
  logic [1:0]  mux_q;
  logic [31:0] src_q;
  logic [31:0] brd_q;
  logic [31:0] res_q;
  logic        res_c_q;
  logic        done_a_q;
  logic        done_b_q;
  logic        s1_valid_q;
  logic        s1_id_q;
  logic [1:0]  starve_q;
  logic [1:0]  starve_d;
  logic        gnt_a;
  logic        gnt_b;
  always_comb begin
    gnt_b = ~reset & bus.req_b & (~bus.req_a | (starve_q == SMAX));
    gnt_a = ~reset & bus.req_a & ~gnt_b;
    starve_d = gnt_b ? 2'd0 : (bus.req_b && starve_q != SMAX) ? starve_q + 2'd1 : starve_q;
  end
  // Operand registers only load on a grant so the shifter inputs stay quiet when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mux_q      <= '0;
      src_q      <= '0;
      brd_q      <= '0;
      res_q      <= '0;
      res_c_q    <= 1'b0;
      done_a_q   <= 1'b0;
      done_b_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      starve_q   <= '0;
    end else begin
      s1_valid_q <= gnt_a | gnt_b;
      if (gnt_a | gnt_b) begin
        s1_id_q <= gnt_b;
        mux_q   <= gnt_b ? bus.mode_b : bus.mode_a;
        src_q   <= gnt_b ? bus.cnt_b : bus.cnt_a;
        brd_q   <= gnt_b ? bus.data_b : bus.data_a;
      end
      if (s1_valid_q) begin
        res_q   <= bus.brlq;
        res_c_q <= bus.brl_carry;
      end
      done_a_q <= s1_valid_q & ~s1_id_q;
      done_b_q <= s1_valid_q & s1_id_q;
      starve_q <= starve_d;
    end
  end
  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.done_a   = done_a_q;
  assign bus.done_b   = done_b_q;
  assign bus.brlmux_0 = mux_q[0];
  assign bus.brlmux_1 = mux_q[1];
  assign bus.srcdp    = src_q;
  assign bus.brld     = brd_q;
  assign bus.res_q    = res_q;
  assign bus.res_c    = res_c_q;
  assign bus.busy     = s1_valid_q;
endmodule

// File: tb/tb_brl_sched.sv
// tb_brl_sched: directed stimulus with a queue scoreboard checking tagged done pulses.
module tb_brl_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  brl_if bus();
  brl_sched #(.STARVE_MAX(3)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  // Stand-in shifter: mode bit 0 rotates left, else shifts left; carry = mode bit 1 ^ data[0].
  assign bus.brlq = bus.brlmux_0
    ? ((bus.brld << bus.srcdp[4:0]) | (bus.brld >> (6'd32 - {1'b0, bus.srcdp[4:0]})))
    : (bus.brld << bus.srcdp[4:0]);
  assign bus.brl_carry = bus.brlmux_1 ^ bus.brld[0];
  typedef struct {logic id; logic [31:0] r; logic c; int cy;} exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  logic        prev_g = 1'b0;
  logic [1:0]  exp_mux = '0;
  logic [31:0] exp_src = '0;
  logic [31:0] exp_brd = '0;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cy < cyc_n) begin
      chk("missed_done", 32'(q[0].cy), 32'(cyc_n));
      void'(q.pop_front());
    end
    if (bus.done_a || bus.done_b) begin
      if (q.size() == 0) chk("unexpected_done", {30'd0, bus.done_b, bus.done_a}, 32'd0);
      else begin
        chk("done_both", 32'(bus.done_a & bus.done_b), 32'd0);
        chk("done_tag", 32'(bus.done_b), 32'(q[0].id));
        chk("done_cycle", 32'(cyc_n), 32'(q[0].cy));
        chk("res_q", bus.res_q, q[0].r);
        chk("res_c", 32'(bus.res_c), 32'(q[0].c));
        void'(q.pop_front());
      end
    end
  end
  task automatic cyc(input logic ra, input logic [1:0] ma, input logic [31:0] ca, input logic [31:0] da,
                     input logic rb, input logic [1:0] mb, input logic [31:0] cb, input logic [31:0] db,
                     input logic ega, input logic egb, input logic [31:0] er, input logic ec);
    exp_t e;
    bus.req_a = ra; bus.mode_a = ma; bus.cnt_a = ca; bus.data_a = da;
    bus.req_b = rb; bus.mode_b = mb; bus.cnt_b = cb; bus.data_b = db;
    @(negedge clk);
    chk("gnt_a", 32'(bus.gnt_a), 32'(ega));
    chk("gnt_b", 32'(bus.gnt_b), 32'(egb));
    chk("busy", 32'(bus.busy), 32'(prev_g));
    chk("srcdp", bus.srcdp, exp_src);
    chk("brld", bus.brld, exp_brd);
    chk("brlmux", {30'd0, bus.brlmux_1, bus.brlmux_0}, {30'd0, exp_mux});
    prev_g = ega | egb;
    if (ega | egb) begin
      e.id = egb; e.r = er; e.c = ec; e.cy = cyc_n + 2;
      q.push_back(e);
      exp_mux = egb ? mb : ma;
      exp_src = egb ? cb : ca;
      exp_brd = egb ? db : da;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'd0, 32'd0, 32'd0, 0, 2'd0, 32'd0, 32'd0, 0, 0, 32'd0, 1'b0);
  endtask
  initial begin
    bus.req_a = 0; bus.mode_a = 0; bus.cnt_a = 0; bus.data_a = 0;
    bus.req_b = 0; bus.mode_b = 0; bus.cnt_b = 0; bus.data_b = 0;
    @(negedge clk);
    chk("rst_res_q", bus.res_q, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", {30'd0, bus.done_b, bus.done_a}, 32'd0);
    chk("rst_srcdp", bus.srcdp, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    // Single A: 0xF << 4 = 0xF0, carry 0 ^ 1 = 1
    cyc(1, 2'b00, 32'h4, 32'hF, 0, 2'd0, 32'd0, 32'd0, 1, 0, 32'hF0, 1'b1);
    idle(3);
    // Contention: A,A,A,B repeating; B rotates 0x80000001 left by 1 = 0x3, carry 1
    for (int i = 0; i < 8; i++)
      if (i % 4 == 3) cyc(1, 2'b00, 32'h1, 32'h10 + i, 1, 2'b01, 32'h1, 32'h80000001, 0, 1, 32'h3, 1'b1);
      else cyc(1, 2'b00, 32'h1, 32'h10 + i, 1, 2'b01, 32'h1, 32'h80000001, 1, 0, 32'h20 + 2 * i, 1'(i % 2));
    idle(3);
    // Back-to-back: count 0 passes data through, carry = data[0]
    cyc(1, 2'b00, 32'h0, 32'h1, 0, 2'd0, 32'd0, 32'd0, 1, 0, 32'h1, 1'b1);
    cyc(1, 2'b00, 32'h0, 32'h2, 0, 2'd0, 32'd0, 32'd0, 1, 0, 32'h2, 1'b0);
    cyc(1, 2'b00, 32'h0, 32'h3, 0, 2'd0, 32'd0, 32'd0, 1, 0, 32'h3, 1'b1);
    cyc(1, 2'b00, 32'h0, 32'h4, 0, 2'd0, 32'd0, 32'd0, 1, 0, 32'h4, 1'b0);
    idle(3);
    // B only: 5 << 2 = 0x14, 6 << 2 = 0x18
    cyc(0, 2'd0, 32'd0, 32'd0, 1, 2'b00, 32'h2, 32'h5, 0, 1, 32'h14, 1'b1);
    cyc(0, 2'd0, 32'd0, 32'd0, 1, 2'b00, 32'h2, 32'h6, 0, 1, 32'h18, 1'b0);
    chk("starve_b_only", 32'(dut.starve_q), 32'd0);
    idle(3);
    // Reset in the cycle after gnt_a: the in-flight op must vanish
    cyc(1, 2'b01, 32'h7, 32'hAA, 0, 2'd0, 32'd0, 32'd0, 1, 0, 32'd0, 1'b0);
    q.delete(q.size() - 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt_a", 32'(bus.gnt_a), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_srcdp", bus.srcdp, 32'd0);
    chk("mid_rst_brld", bus.brld, 32'd0);
    chk("mid_rst_mux", {30'd0, bus.brlmux_1, bus.brlmux_0}, 32'd0);
    chk("mid_rst_res_q", bus.res_q, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    prev_g = 1'b0; exp_mux = '0; exp_src = '0; exp_brd = '0;
    // First edge after release: 2 << 3 = 0x10, carry 1 ^ 0 = 1
    cyc(1, 2'b10, 32'h3, 32'h2, 0, 2'd0, 32'd0, 32'd0, 1, 0, 32'h10, 1'b1);
    idle(10);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
